pong_vga_renderer: RTL and testbench
====================================

# pong_vga_renderer

Display end of the ball-and-paddle datapath. It takes the game controller's ball, paddle, score and mode outputs and drives a 640x480@60 Hz VGA raster: 12-bit RGB plus active-low syncs. Game state is sampled once per frame at vertical-blank start, so a frame never tears. The block sits between the game controller and the board VGA pins.

## Interface
- CLK_DIV, 4, clk cycles per pixel (4 gives 25 MHz from 100 MHz; 1 means a pixel every cycle)
- clk  in  1  system clock
- rst  in  1  reset rst, asynchronous, active-high
- p1_y, p2_y  in  11  paddle centre rows
- ball_x, ball_y  in  11  ball centre
- p1_score, p2_score  in  5  scores, 0..31
- mode  in  2  00 tennis, 01 soccer, 10 squash, 11 practice
- bat_size  in  1  0: paddle half-height 25; 1: half-height 15
- hsync, vsync  out  1  active-low syncs
- rgb  out  12  {R4,G4,B4}
- frame_start  out  1  one-clk pulse on the input-latch cycle

## Operation
- Pixel tick: divider 0..CLK_DIV-1; tick when the divider equals CLK_DIV-1. All raster logic advances only on tick.
- hcount 0..799: visible 0..639, front porch 640..655, sync 656..751, back 752..799.
- vcount 0..524: visible 0..479, front porch 480..489, sync 490..491, back 492..524.
- Both counters wrap to 0. vcount increments on the tick where hcount wraps.
- Latch: on the tick with hcount=0 and vcount=480, register all game inputs and pulse frame_start for that one clk. Drawing uses only latched copies.
- Half-height h = 15 if the latched bat_size is 1, else 25.
- Containment tests use addition only, 12-bit, so a centre below h never underflows: covered iff py+h >= p and py <= c+h.
- Ball: 5x5, x in ball_x±2, y in ball_y±2, same addition rule.
- Paddles:
  - Modes 00/01: P1 at x 40..50 (p1_y); P2 at x 590..600 (p2_y).
  - Mode 10: P1 at x 590..600; P2 at x 570..580.
  - Mode 11: P1 only, at x 590..600.
- Walls:
  - All modes: top y<=30 and bottom y>=450.
  - Modes 01/10/11: left wall x<=30.
  - Mode 01 only: right wall x>=610.
  - Mode 01 left/right walls are omitted for y 134..344 (goal mouth).
- Net: tennis only, x 319..320, drawn where (y>>3) is even.
- Score bars at y 8..19, one 4-px block per point, 6-px pitch:
  - P1 blocks start at x=40 and run rightward.
  - P2 blocks end at x=599 and run leftward.
  - Block k (0-based) is drawn iff k < score; score 0 draws nothing.
- Priority and colours:
  - ball FF0 > P1 F00 > P2 00F > P1 score F00 > P2 score 00F > wall FFF > net 888 > background 000.
  - Outside the visible area rgb = 000.
- Reset values:
  - counters 0, divider 0.
  - hsync=vsync=1, rgb=000, frame_start=0.
  - Latched state: ball 60,60; paddles 240; scores 0; mode 00; bat_size 0.
- Reset mid-frame: all outputs return to reset values asynchronously. The raster restarts at (0,0) on the first tick after release.

## Timing
- Pixel pipeline: rgb, hsync and vsync are registered together one tick after the counter value they describe. Sync and colour therefore stay aligned; the fixed one-pixel shift is acceptable.
- hsync low for exactly 96 ticks per line; vsync low for exactly 2 lines (1600 ticks). Frame = 420,000 ticks.
- Input changes after the latch tick appear no earlier than the next frame's first visible pixel. Input changes before the latch tick appear in the frame that begins at vcount 0 following it.
- frame_start occurs exactly once per 420,000*CLK_DIV clk cycles.

## Structure
- Package pong_pkg holds:
  - H/V timing constants.
  - Field geometry: walls 30/450/610, goal 134..344, paddle columns, score bar origin and pitch.
  - Colour constants.
  - Mode encoding typedef, shared with the game controller.
- Sub-module vga_timing: divider, hcount/vcount, raw sync, visible flag, tick. The renderer instantiates it once and adds the latch, object decode, priority mux and output registers.

## Test plan
- Reset, CLK_DIV=1: after release hsync=vsync=1 and rgb=000. First hsync fall is 657 clks after release; line period is 800; vsync low for 1600 clks per 420,000.
- Latch: ball_x=320, ball_y=240 before vcount 480. Pixel (320,240) is FF0 next frame and (323,240) is 000. Move the ball mid-frame: no change until the frame after the next latch.
- Underflow: mode 00, p1_y=10, bat_size=0. Pixels x=45, y=0..35 are F00 and y=36 is not F00; top-wall rows are overridden by the paddle.
- Soccer goal: mode 01. Pixel (20,200) is 000 and (20,100) is FFF. Pixel (615,344) is 000 and (615,345) is FFF.
- Scores: p1_score=3, p2_score=31. P1 blocks cover x 40..43, 46..49, 52..55 and (58,10) is 000. P2 rightmost block is x 596..599 and leftmost is x 416..419.
- Mode 11 with bat_size=1: only a 590..600 paddle, rows p1_y±15. No P2 pixels appear at x 40..50 or 570..580.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared types and constants for the pong display path: VGA 640x480 timing,
// playfield geometry, colours and the game-mode encoding used by the controller.
package pong_pkg;

  localparam int H_VISIBLE    = 640;
  localparam int H_SYNC_START = 656;
  localparam int H_SYNC_END   = 751;
  localparam int H_TOTAL      = 800;
  localparam int V_VISIBLE    = 480;
  localparam int V_SYNC_START = 490;
  localparam int V_SYNC_END   = 491;
  localparam int V_TOTAL      = 525;

  localparam int WALL_TOP      = 30;
  localparam int WALL_BOTTOM   = 450;
  localparam int WALL_LEFT     = 30;
  localparam int WALL_RIGHT    = 610;
  localparam int GOAL_TOP      = 134;
  localparam int GOAL_BOTTOM   = 344;
  localparam int COL_LEFT      = 40;
  localparam int COL_RIGHT     = 590;
  localparam int COL_SQUASH_P2 = 570;
  localparam int PADDLE_W      = 10;
  localparam int HALF_BIG      = 25;
  localparam int HALF_SMALL    = 15;
  localparam int BALL_HALF     = 2;
  localparam int NET_X         = 319;
  localparam int SCORE_Y_TOP   = 8;
  localparam int SCORE_Y_BOT   = 19;
  localparam int SCORE_P1_X    = 40;
  localparam int SCORE_P2_X    = 599;
  localparam int SCORE_PITCH   = 6;
  localparam int SCORE_BLOCK   = 4;

  localparam logic [11:0] COLOUR_BALL = 12'hFF0;
  localparam logic [11:0] COLOUR_P1   = 12'hF00;
  localparam logic [11:0] COLOUR_P2   = 12'h00F;
  localparam logic [11:0] COLOUR_WALL = 12'hFFF;
  localparam logic [11:0] COLOUR_NET  = 12'h888;
  localparam logic [11:0] COLOUR_BG   = 12'h000;

  typedef enum logic [1:0] {
    MODE_TENNIS   = 2'b00,
    MODE_SOCCER   = 2'b01,
    MODE_SQUASH   = 2'b10,
    MODE_PRACTICE = 2'b11
  } mode_t;

  typedef struct packed {
    logic [10:0] ball_x;
    logic [10:0] ball_y;
    logic [10:0] p1_y;
    logic [10:0] p2_y;
    logic [4:0]  p1_score;
    logic [4:0]  p2_score;
    mode_t       mode;
    logic        bat_size;
  } game_t;

  localparam game_t GAME_RESET = '{ball_x: 11'd60, ball_y: 11'd60, p1_y: 11'd240,
                                   p2_y: 11'd240, p1_score: 5'd0, p2_score: 5'd0,
                                   mode: MODE_TENNIS, bat_size: 1'b0};

  // Range test written with additions only so a centre smaller than h cannot wrap.
  function automatic logic covers(input logic [11:0] c, input logic [11:0] p,
                                  input logic [11:0] h);
    return (p + h >= c) && (p <= c + h);
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel-rate divider and 800x525 raster counters; produces raw (unregistered)
// syncs and the visible-area flag for the current counter position.
module vga_timing
  import pong_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic       tick,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       hsync_raw,
  output logic       vsync_raw,
  output logic       visible
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] divider;

  assign tick = (divider == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      divider <= '0;
    end else if (tick) begin
      divider <= '0;
    end else begin
      divider <= divider + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcount <= '0;
      vcount <= '0;
    end else if (tick) begin
      if (hcount == 10'(H_TOTAL - 1)) begin
        hcount <= '0;
        vcount <= (vcount == 10'(V_TOTAL - 1)) ? 10'd0 : vcount + 1'b1;
      end else begin
        hcount <= hcount + 1'b1;
      end
    end
  end

  assign hsync_raw = !((hcount >= 10'(H_SYNC_START)) && (hcount <= 10'(H_SYNC_END)));
  assign vsync_raw = !((vcount >= 10'(V_SYNC_START)) && (vcount <= 10'(V_SYNC_END)));
  assign visible   = (hcount < 10'(H_VISIBLE)) && (vcount < 10'(V_VISIBLE));

endmodule

// File: rtl/pong_vga_renderer.sv
// Draws ball, paddles, scores, walls and net onto a 640x480 VGA raster from a
// once-per-frame snapshot of the game state taken at vertical-blank start.
module pong_vga_renderer
  import pong_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] p1_y,
  input  logic [10:0] p2_y,
  input  logic [10:0] ball_x,
  input  logic [10:0] ball_y,
  input  logic [4:0]  p1_score,
  input  logic [4:0]  p2_score,
  input  logic [1:0]  mode,
  input  logic        bat_size,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] rgb,
  output logic        frame_start
);

  logic        tick, hsync_raw, vsync_raw, visible, latch_now;
  logic [9:0]  hcount, vcount;
  game_t       game;
  logic [11:0] x, y, half, p1_col, p2_col, p1_off, p2_off, colour;
  logic        p2_on, in_ball, in_p1, in_p2, in_band, in_s1, in_s2;
  logic        in_goal, in_wall, in_net;

  vga_timing #(.CLK_DIV(CLK_DIV)) u_timing (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .hcount    (hcount),
    .vcount    (vcount),
    .hsync_raw (hsync_raw),
    .vsync_raw (vsync_raw),
    .visible   (visible)
  );

  assign latch_now   = tick && (hcount == 10'd0) && (vcount == 10'(V_VISIBLE));
  assign frame_start = latch_now;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      game <= GAME_RESET;
    end else if (latch_now) begin
      game <= '{ball_x: ball_x, ball_y: ball_y, p1_y: p1_y, p2_y: p2_y,
                p1_score: p1_score, p2_score: p2_score, mode: mode_t'(mode),
                bat_size: bat_size};
    end
  end

  assign x    = {2'b00, hcount};
  assign y    = {2'b00, vcount};
  assign half = game.bat_size ? 12'(HALF_SMALL) : 12'(HALF_BIG);

  always_comb begin
    p1_col = 12'(COL_LEFT);
    p2_col = 12'(COL_RIGHT);
    p2_on  = 1'b1;
    case (game.mode)
      MODE_SQUASH: begin
        p1_col = 12'(COL_RIGHT);
        p2_col = 12'(COL_SQUASH_P2);
      end
      MODE_PRACTICE: begin
        p1_col = 12'(COL_RIGHT);
        p2_on  = 1'b0;
      end
      default: ;
    endcase
  end

  assign in_ball = covers({1'b0, game.ball_x}, x, 12'(BALL_HALF)) &&
                   covers({1'b0, game.ball_y}, y, 12'(BALL_HALF));
  assign in_p1   = (x >= p1_col) && (x <= p1_col + 12'(PADDLE_W)) &&
                   covers({1'b0, game.p1_y}, y, half);
  assign in_p2   = p2_on && (x >= p2_col) && (x <= p2_col + 12'(PADDLE_W)) &&
                   covers({1'b0, game.p2_y}, y, half);

  // Offset from each bar's anchor; block k occupies offsets 6k..6k+3.
  assign p1_off  = x - 12'(SCORE_P1_X);
  assign p2_off  = 12'(SCORE_P2_X) - x;
  assign in_band = (y >= 12'(SCORE_Y_TOP)) && (y <= 12'(SCORE_Y_BOT));
  assign in_s1   = in_band && (x >= 12'(SCORE_P1_X)) &&
                   ((p1_off % 12'(SCORE_PITCH)) < 12'(SCORE_BLOCK)) &&
                   (p1_off < 12'(game.p1_score) * 12'(SCORE_PITCH));
  assign in_s2   = in_band && (x <= 12'(SCORE_P2_X)) &&
                   ((p2_off % 12'(SCORE_PITCH)) < 12'(SCORE_BLOCK)) &&
                   (p2_off < 12'(game.p2_score) * 12'(SCORE_PITCH));

  assign in_goal = (y >= 12'(GOAL_TOP)) && (y <= 12'(GOAL_BOTTOM));
  assign in_wall = (y <= 12'(WALL_TOP)) || (y >= 12'(WALL_BOTTOM)) ||
                   ((game.mode != MODE_TENNIS) && (x <= 12'(WALL_LEFT)) &&
                    !((game.mode == MODE_SOCCER) && in_goal)) ||
                   ((game.mode == MODE_SOCCER) && (x >= 12'(WALL_RIGHT)) && !in_goal);
  assign in_net  = (game.mode == MODE_TENNIS) &&
                   ((x == 12'(NET_X)) || (x == 12'(NET_X + 1))) && !y[3];

  always_comb begin
    colour = COLOUR_BG;
    if (in_ball)      colour = COLOUR_BALL;
    else if (in_p1)   colour = COLOUR_P1;
    else if (in_p2)   colour = COLOUR_P2;
    else if (in_s1)   colour = COLOUR_P1;
    else if (in_s2)   colour = COLOUR_P2;
    else if (in_wall) colour = COLOUR_WALL;
    else if (in_net)  colour = COLOUR_NET;
  end

  // Colour and syncs share one register stage so they stay pixel-aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync <= 1'b1;
      vsync <= 1'b1;
      rgb   <= COLOUR_BG;
    end else if (tick) begin
      hsync <= hsync_raw;
      vsync <= vsync_raw;
      rgb   <= visible ? colour : COLOUR_BG;
    end
  end

endmodule

// File: tb/tb_pong_vga_renderer.sv
// Scoreboard bench for pong_vga_renderer at one pixel per clock: a reference
// model predicts sampled raster points, a negedge monitor checks them in order.
module tb_pong_vga_renderer;

  localparam int FRAME = 420000;
  localparam int LATCH_R = 480 * 800;

  typedef struct {
    int bx; int by; int p1y; int p2y; int p1s; int p2s; int mode; int bat;
  } cfg_t;

  typedef struct {
    int          cyc;
    logic [14:0] exp;
    int          x;
    int          y;
  } entry_t;

  logic        clk, rst;
  logic [10:0] p1_y, p2_y, ball_x, ball_y;
  logic [4:0]  p1_score, p2_score;
  logic [1:0]  mode;
  logic        bat_size;
  logic        hsync, vsync, frame_start;
  logic [11:0] rgb;

  int     cyc;
  int     total = 0;
  int     bad = 0;
  int     rs[$];
  entry_t sb[$];
  entry_t mon_e;
  cfg_t   cfg, latched;
  cfg_t   DEF = '{60, 60, 240, 240, 0, 0, 0, 0};

  pong_vga_renderer #(.CLK_DIV(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .p1_y       (p1_y),
    .p2_y       (p2_y),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .p1_score   (p1_score),
    .p2_score   (p2_score),
    .mode       (mode),
    .bat_size   (bat_size),
    .hsync      (hsync),
    .vsync      (vsync),
    .rgb        (rgb),
    .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  function automatic int iabs(int v);
    return (v < 0) ? -v : v;
  endfunction

  // What the screen should show at (x,y) given a snapshot, straight from the drawing rules.
  function automatic logic [11:0] modelColour(int x, int y, cfg_t g);
    int  half = g.bat ? 15 : 25;
    int  p1x = (g.mode >= 2) ? 590 : 40;
    int  p2x = (g.mode == 2) ? 570 : 590;
    bit  goal = (y >= 134 && y <= 344);
    if (iabs(x - g.bx) <= 2 && iabs(y - g.by) <= 2) return 12'hFF0;
    if (x >= p1x && x <= p1x + 10 && iabs(y - g.p1y) <= half) return 12'hF00;
    if (g.mode != 3 && x >= p2x && x <= p2x + 10 && iabs(y - g.p2y) <= half) return 12'h00F;
    if (y >= 8 && y <= 19) begin
      for (int k = 0; k < g.p1s; k++)
        if (x >= 40 + 6 * k && x <= 43 + 6 * k) return 12'hF00;
      for (int k = 0; k < g.p2s; k++)
        if (x >= 596 - 6 * k && x <= 599 - 6 * k) return 12'h00F;
    end
    if (y <= 30 || y >= 450) return 12'hFFF;
    if (g.mode != 0 && x <= 30 && !(g.mode == 1 && goal)) return 12'hFFF;
    if (g.mode == 1 && x >= 610 && !goal) return 12'hFFF;
    if (g.mode == 0 && (x == 319 || x == 320) && ((y / 8) % 2 == 0)) return 12'h888;
    return 12'h000;
  endfunction

  function automatic logic [14:0] expectAt(int r, cfg_t g);
    int h = r % 800;
    int v = r / 800;
    logic hs = !(h >= 656 && h <= 751);
    logic vs = !(v == 490 || v == 491);
    logic fs = (((r + 1) % FRAME) == LATCH_R);
    logic [11:0] c = (h < 640 && v < 480) ? modelColour(h, v, g) : 12'h000;
    return {fs, hs, vs, c};
  endfunction

  function automatic cfg_t randomCfg(int m, int b);
    cfg_t g;
    g.bx = $urandom_range(0, 660);  g.by = $urandom_range(0, 500);
    g.p1y = $urandom_range(0, 500); g.p2y = $urandom_range(0, 500);
    g.p1s = $urandom_range(0, 31);  g.p2s = $urandom_range(0, 31);
    g.mode = m; g.bat = b;
    return g;
  endfunction

  function automatic void addXY(int x, int y);
    if (x >= 0 && x < 800 && y >= 0 && y < 525) rs.push_back(y * 800 + x);
  endfunction

  function automatic void buildList(cfg_t g);
    int half = g.bat ? 15 : 25;
    int xs[12] = '{39, 40, 45, 50, 51, 569, 570, 575, 580, 589, 595, 601};
    int hx[8] = '{0, 639, 640, 655, 656, 751, 752, 799};
    int lines[9] = '{0, 1, 479, 480, 489, 490, 491, 492, 524};
    int wy[8] = '{30, 31, 133, 134, 344, 345, 449, 450};
    rs.delete();
    addXY(320, 240); addXY(323, 240);
    addXY(20, 200); addXY(20, 100); addXY(615, 344); addXY(615, 345); addXY(615, 100);
    for (int y = 0; y <= 36; y++) addXY(45, y);
    for (int x = 38; x <= 60; x++) addXY(x, 10);
    for (int x = 412; x <= 420; x++) addXY(x, 10);
    for (int x = 594; x <= 601; x++) addXY(x, 10);
    for (int y = 100; y <= 116; y++) addXY(319, y);
    foreach (wy[i]) begin addXY(30, wy[i]); addXY(31, wy[i]); addXY(609, wy[i]); addXY(610, wy[i]); end
    foreach (xs[i]) begin
      addXY(xs[i], g.p1y - half - 1); addXY(xs[i], g.p1y - half); addXY(xs[i], g.p1y + half);
      addXY(xs[i], g.p1y + half + 1); addXY(xs[i], g.p2y - half - 1); addXY(xs[i], g.p2y - half);
      addXY(xs[i], g.p2y + half); addXY(xs[i], g.p2y + half + 1);
    end
    for (int dx = -3; dx <= 3; dx++)
      for (int dy = -3; dy <= 3; dy++) addXY(g.bx + dx, g.by + dy);
    for (int i = 0; i < 200; i++) addXY($urandom_range(0, 639), $urandom_range(0, 479));
    foreach (lines[i]) foreach (hx[j]) addXY(hx[j], lines[i]);
    rs.push_back(LATCH_R - 2); rs.push_back(LATCH_R - 1); rs.push_back(LATCH_R);
  endfunction

  // Expected responses go into the scoreboard in raster order, keyed by clock count.
  task automatic pushList(int frame, cfg_t g, int limit);
    entry_t e;
    rs.sort();
    foreach (rs[i]) begin
      if (i > 0 && rs[i] == rs[i - 1]) continue;
      e.cyc = frame * FRAME + rs[i] + 1;
      if (e.cyc > limit) continue;
      e.exp = expectAt(rs[i], g);
      e.x = rs[i] % 800;
      e.y = rs[i] / 800;
      sb.push_back(e);
    end
  endtask

  task automatic checkOutput(string name, int x, int y, logic [14:0] got, logic [14:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s cyc=%0d x=%0d y=%0d got{fs,hs,vs,rgb}=%h want=%h",
               name, cyc, x, y, got, want);
    end
  endtask

  task automatic applyStimulus(cfg_t g);
    ball_x = 11'(g.bx);    ball_y = 11'(g.by);
    p1_y = 11'(g.p1y);     p2_y = 11'(g.p2y);
    p1_score = 5'(g.p1s);  p2_score = 5'(g.p2s);
    mode = 2'(g.mode);     bat_size = 1'(g.bat);
  endtask

  task automatic waitCycle(int target);
    while (cyc < target) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        mon_e = sb.pop_front();
        total++;
        bad++;
        $display("[TB] FAIL missed_sample cyc=%0d got=none want=%0d", cyc, mon_e.cyc);
      end
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        mon_e = sb.pop_front();
        checkOutput("raster", mon_e.x, mon_e.y, {frame_start, hsync, vsync, rgb}, mon_e.exp);
      end
    end
  end

  initial begin
    int cuts[2] = '{400, 700};
    rst = 1'b1;
    applyStimulus(DEF);
    #3;
    checkOutput("reset_hold", -1, -1, {frame_start, hsync, vsync, rgb}, 15'h3000);

    // Let the raster run briefly, then yank reset mid-line and expect instant idle outputs.
    for (int i = 0; i < 2; i++) begin
      sb.delete();
      rs = {99, 398, 399, 655, 656, 657};
      @(negedge clk);
      rst = 1'b0;
      checkOutput("reset_release", -1, -1, {frame_start, hsync, vsync, rgb}, 15'h3000);
      pushList(0, DEF, cuts[i]);
      waitCycle(cuts[i]);
      @(posedge clk);
      #2 rst = 1'b1;
      #1 checkOutput("reset_async", -1, -1, {frame_start, hsync, vsync, rgb}, 15'h3000);
      @(negedge clk);
    end

    sb.delete();
    cfg = '{320, 240, 10, $urandom_range(100, 400), 3, 31, 0, 0};
    applyStimulus(cfg);
    @(negedge clk);
    rst = 1'b0;
    buildList(DEF);
    pushList(0, DEF, 32'h7fffffff);

    for (int l = 0; l < 4; l++) begin
      waitCycle(l * FRAME + LATCH_R + 1);
      latched = cfg;
      buildList(latched);
      pushList(l + 1, latched, 32'h7fffffff);
      if (l < 3) begin
        waitCycle(l * FRAME + LATCH_R + 50001);
        case (l)
          0:       cfg = randomCfg(1, $urandom_range(0, 1));
          1:       cfg = randomCfg(3, 1);
          default: cfg = randomCfg(2, $urandom_range(0, 1));
        endcase
        applyStimulus(cfg);
      end
    end

    waitCycle(5 * FRAME + 2);
    checkOutput("scoreboard_drained", -1, -1, 15'(sb.size()), 15'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
